// File: rtl/video_timing_gen.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing generator. Two free-running counters (pixel, line) walk a
// frame described by four values per axis: active, sync start, sync end,
// total. The counters are decoded into registered HSync/VSync/HBlank/VBlank/
// DE and a frame-start strobe. A new timing can be offered at any time over
// a valid/ready handshake; it is checked, parked in a shadow register and
// only copied into the live timing when the raster wraps to (0,0).
//
// Ports:
//   clk_vid      video clock
//   reset_n      asynchronous active-low reset
//   ce_pix       pixel enable; raster state moves only when high
//   cfg_h/cfg_v  offered timing, packed {total, sync_end, sync_start, active}
//   cfg_valid    offer present
//   cfg_ready    shadow empty, an offer may be taken
//   cfg_err      one-clock pulse: offered timing was illegal and dropped
//   hcnt/vcnt    current pixel / line
//   HSync/VSync  sync outputs at HS_POL/VS_POL when active
//   HBlank/VBlank/DE  blanking and display-enable
//   frame_start  high while the raster sits at (0,0)
// ---------------------------------------------------------------------------
module video_timing_gen #(
    parameter int W      = 12,
    parameter int H_ACT  = 320,
    parameter int H_SS   = 336,
    parameter int H_SE   = 368,
    parameter int H_TOT  = 426,
    parameter int V_ACT  = 240,
    parameter int V_SS   = 244,
    parameter int V_SE   = 247,
    parameter int V_TOT  = 262,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input  logic           clk_vid,
    input  logic           reset_n,
    input  logic           ce_pix,
    input  logic [4*W-1:0] cfg_h,
    input  logic [4*W-1:0] cfg_v,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    output logic           cfg_err,
    output logic [W-1:0]   hcnt,
    output logic [W-1:0]   vcnt,
    output logic           HSync,
    output logic           VSync,
    output logic           HBlank,
    output logic           VBlank,
    output logic           DE,
    output logic           frame_start
);

    // Field order matches the cfg_* packing: act sits in the low bits.
    typedef struct packed {
        logic [W-1:0] tot;
        logic [W-1:0] se;
        logic [W-1:0] ss;
        logic [W-1:0] act;
    } timing_t;

    typedef enum logic {
        CFG_IDLE,
        CFG_PENDING
    } cfg_state_t;

    localparam timing_t RESET_H = {W'(H_TOT), W'(H_SE), W'(H_SS), W'(H_ACT)};
    localparam timing_t RESET_V = {W'(V_TOT), W'(V_SE), W'(V_SS), W'(V_ACT)};

    function automatic logic axis_legal(input timing_t t);
        return (t.act != '0) && (t.act < t.ss) && (t.ss < t.se) &&
               (t.se <= t.tot) && (t.tot >= W'(2));
    endfunction

    // Live timing, shadow and config state
    timing_t    live_h_q, live_v_q;
    timing_t    shadow_h_q, shadow_v_q;
    cfg_state_t state_q;
    logic       cfg_ready_q, cfg_err_q;

    // Raster state
    logic [W-1:0] hcnt_q, vcnt_q;
    logic         hsync_q, vsync_q, hblank_q, vblank_q, de_q, frame_start_q;

    // Next-state / decode
    logic [W-1:0] hcnt_d, vcnt_d;
    logic         h_wrap, frame_wrap, apply;
    timing_t      dec_h, dec_v;
    logic         hsync_d, vsync_d, hblank_d, vblank_d, de_d, frame_start_d;
    logic         cfg_ok;

    assign cfg_ok = axis_legal(timing_t'(cfg_h)) && axis_legal(timing_t'(cfg_v));

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        hcnt_d     = hcnt_q + W'(1);
        vcnt_d     = vcnt_q;
        h_wrap     = (hcnt_q == live_h_q.tot - W'(1));
        frame_wrap = 1'b0;

        if (h_wrap) begin
            hcnt_d = '0;
            if (vcnt_q == live_v_q.tot - W'(1)) begin
                vcnt_d     = '0;
                frame_wrap = 1'b1;
            end else begin
                vcnt_d = vcnt_q + W'(1);
            end
        end

        // The edge that lands on (0,0) already decodes with the new timing.
        apply = ce_pix && frame_wrap && (state_q == CFG_PENDING);
        dec_h = apply ? shadow_h_q : live_h_q;
        dec_v = apply ? shadow_v_q : live_v_q;

        hblank_d      = (hcnt_d >= dec_h.act);
        vblank_d      = (vcnt_d >= dec_v.act);
        de_d          = ~(hblank_d | vblank_d);
        hsync_d       = ((hcnt_d >= dec_h.ss) && (hcnt_d < dec_h.se)) ? HS_POL : ~HS_POL;
        vsync_d       = ((vcnt_d >= dec_v.ss) && (vcnt_d < dec_v.se)) ? VS_POL : ~VS_POL;
        frame_start_d = (hcnt_d == '0) && (vcnt_d == '0);
    end

    // Raster counters, decoded outputs and live timing.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            de_q          <= 1'b1;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            frame_start_q <= 1'b0;
            live_h_q      <= RESET_H;
            live_v_q      <= RESET_V;
        end else if (ce_pix) begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            frame_start_q <= frame_start_d;
            // VSync only moves at the start of a line.
            if (h_wrap) begin
                vsync_q <= vsync_d;
            end
            if (apply) begin
                live_h_q <= shadow_h_q;
                live_v_q <= shadow_v_q;
            end
        end
    end

    // Config handshake FSM. Runs every clock, independent of ce_pix.
    // NOTE: the shadow is reset as well, so it never holds X even though it is
    // only consumed while PENDING.
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CFG_IDLE;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
            shadow_h_q  <= RESET_H;
            shadow_v_q  <= RESET_V;
        end else begin
            cfg_err_q <= 1'b0;
            case (state_q)
                CFG_IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_ok) begin
                            shadow_h_q  <= timing_t'(cfg_h);
                            shadow_v_q  <= timing_t'(cfg_v);
                            state_q     <= CFG_PENDING;
                            cfg_ready_q <= 1'b0;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                CFG_PENDING: begin
                    if (apply) begin
                        state_q     <= CFG_IDLE;
                        cfg_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= CFG_IDLE;
                    cfg_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign hcnt        = hcnt_q;
    assign vcnt        = vcnt_q;
    assign HSync       = hsync_q;
    assign VSync       = vsync_q;
    assign HBlank      = hblank_q;
    assign VBlank      = vblank_q;
    assign DE          = de_q;
    assign frame_start = frame_start_q;
    assign cfg_ready   = cfg_ready_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//
// Drives two generators (HS_POL=0 and HS_POL=1) with identical stimulus and
// compares them after every clock against a frame-level model: the raster
// position is a single pixel index into the frame, hcnt/vcnt are its
// remainder/quotient by the line length, and a pending timing is swapped in
// when the index returns to zero.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

    localparam int W = 12;

    typedef struct {
        int act;
        int ss;
        int se;
        int tot;
    } tm_t;

    localparam tm_t PH = '{act: 8, ss: 10, se: 12, tot: 14};
    localparam tm_t PV = '{act: 4, ss: 5,  se: 6,  tot: 8};

    logic           clk_vid = 1'b0;
    logic           reset_n = 1'b0;
    logic           ce_pix = 1'b0;
    logic [4*W-1:0] cfg_h = '0;
    logic [4*W-1:0] cfg_v = '0;
    logic           cfg_valid = 1'b0;

    logic           cfg_ready, cfg_err, HSync, VSync, HBlank, VBlank, DE, frame_start;
    logic [W-1:0]   hcnt, vcnt;
    logic           p_cfg_ready, p_cfg_err, p_HSync, p_VSync, p_HBlank, p_VBlank, p_DE;
    logic           p_frame_start;
    logic [W-1:0]   p_hcnt, p_vcnt;

    int checks = 0;
    int errors = 0;

    // Model state
    int  m_pix;
    tm_t mh, mv, sh, sv;
    bit  m_pend, m_fs, m_err;

    always #5 clk_vid = ~clk_vid;

    video_timing_gen #(
        .W(W), .H_ACT(8), .H_SS(10), .H_SE(12), .H_TOT(14),
        .V_ACT(4), .V_SS(5), .V_SE(6), .V_TOT(8), .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_dut (
        .clk_vid(clk_vid), .reset_n(reset_n), .ce_pix(ce_pix),
        .cfg_h(cfg_h), .cfg_v(cfg_v), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err),
        .hcnt(hcnt), .vcnt(vcnt),
        .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
        .DE(DE), .frame_start(frame_start)
    );

    video_timing_gen #(
        .W(W), .H_ACT(8), .H_SS(10), .H_SE(12), .H_TOT(14),
        .V_ACT(4), .V_SS(5), .V_SE(6), .V_TOT(8), .HS_POL(1'b1), .VS_POL(1'b0)
    ) u_pol (
        .clk_vid(clk_vid), .reset_n(reset_n), .ce_pix(ce_pix),
        .cfg_h(cfg_h), .cfg_v(cfg_v), .cfg_valid(cfg_valid),
        .cfg_ready(p_cfg_ready), .cfg_err(p_cfg_err),
        .hcnt(p_hcnt), .vcnt(p_vcnt),
        .HSync(p_HSync), .VSync(p_VSync), .HBlank(p_HBlank), .VBlank(p_VBlank),
        .DE(p_DE), .frame_start(p_frame_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4*W-1:0] pack(input int act, input int ss, input int se, input int tot);
        return {W'(tot), W'(se), W'(ss), W'(act)};
    endfunction

    function automatic tm_t unpack(input logic [4*W-1:0] c);
        tm_t t;
        t.act = int'(c[W-1:0]);
        t.ss  = int'(c[2*W-1:W]);
        t.se  = int'(c[3*W-1:2*W]);
        t.tot = int'(c[4*W-1:3*W]);
        return t;
    endfunction

    function automatic bit legal(input tm_t t);
        return (t.act > 0) && (t.act < t.ss) && (t.ss < t.se) && (t.se <= t.tot) && (t.tot >= 2);
    endfunction

    function automatic logic [4*W-1:0] rand_legal(input int max_act);
        int a, s, e, t;
        a = $urandom_range(1, max_act);
        s = a + $urandom_range(1, 3);
        e = s + $urandom_range(1, 3);
        t = e + $urandom_range(0, 3);
        return pack(a, s, e, t);
    endfunction

    function automatic logic [4*W-1:0] rand_junk();
        return pack($urandom_range(0, 12), $urandom_range(0, 12),
                    $urandom_range(0, 12), $urandom_range(0, 12));
    endfunction

    task automatic model_reset();
        m_pix  = 0;
        mh     = PH;
        mv     = PV;
        m_pend = 1'b0;
        m_fs   = 1'b0;
        m_err  = 1'b0;
    endtask

    // Expected outputs for the current model state.
    task automatic compare_all(input string tag);
        int h, v;
        bit in_hs, in_vs, hb, vb;
        h     = m_pix % mh.tot;
        v     = m_pix / mh.tot;
        hb    = (h >= mh.act);
        vb    = (v >= mv.act);
        in_hs = (h >= mh.ss) && (h < mh.se);
        in_vs = (v >= mv.ss) && (v < mv.se);
        check({tag, ":hcnt"},   32'(hcnt), 32'(h));
        check({tag, ":vcnt"},   32'(vcnt), 32'(v));
        check({tag, ":HBlank"}, 32'(HBlank), 32'(hb));
        check({tag, ":VBlank"}, 32'(VBlank), 32'(vb));
        check({tag, ":DE"},     32'(DE), 32'(!(hb || vb)));
        check({tag, ":HSync"},  32'(HSync), 32'(!in_hs));
        check({tag, ":VSync"},  32'(VSync), 32'(!in_vs));
        check({tag, ":frame_start"}, 32'(frame_start), 32'(m_fs));
        check({tag, ":cfg_ready"},   32'(cfg_ready), 32'(!m_pend));
        check({tag, ":cfg_err"},     32'(cfg_err), 32'(m_err));
        // Second instance: identical except HSync is active-high.
        check({tag, ":pol_inst"},
              {p_hcnt, p_vcnt, p_HBlank, p_VBlank, p_DE, p_HSync, p_VSync,
               p_frame_start, p_cfg_ready, p_cfg_err},
              {W'(h), W'(v), hb, vb, !(hb || vb), in_hs, !in_vs, m_fs, !m_pend, m_err});
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic step(input string tag, input bit ce, input bit valid,
                        input logic [4*W-1:0] ch, input logic [4*W-1:0] cv);
        bit xfer, ok;
        ce_pix    = ce;
        cfg_valid = valid;
        cfg_h     = ch;
        cfg_v     = cv;
        @(posedge clk_vid);
        xfer = valid && !m_pend;
        ok   = legal(unpack(ch)) && legal(unpack(cv));
        if (ce) begin
            m_pix = (m_pix + 1) % (mh.tot * mv.tot);
            m_fs  = (m_pix == 0);
            if (m_pix == 0 && m_pend) begin
                mh     = sh;
                mv     = sv;
                m_pend = 1'b0;
            end
        end
        if (xfer && ok) begin
            sh     = unpack(ch);
            sv     = unpack(cv);
            m_pend = 1'b1;
        end
        m_err = xfer && !ok;
        #1;
        compare_all(tag);
    endtask

    // Asynchronous reset between clock edges, checked before any edge.
    task automatic async_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all({tag, "_async"});
        @(posedge clk_vid);
        #1;
        compare_all({tag, "_held"});
        reset_n = 1'b1;
    endtask

    initial begin
        int fs_cnt;
        int r;
        bit done;
        logic [4*W-1:0] pv_cfg;

        pv_cfg = pack(PV.act, PV.ss, PV.se, PV.tot);
        model_reset();

        // Reset values
        repeat (2) @(posedge clk_vid);
        #1;
        compare_all("reset");
        reset_n = 1'b1;

        // Two full frames at full rate: 14-clk lines, 112-clk frames
        fs_cnt = 0;
        for (int i = 0; i < 224; i++) begin
            step("full_rate", 1'b1, 1'b0, rand_junk(), rand_junk());
            if (frame_start) fs_cnt++;
        end
        check("frame_start_count", 32'(fs_cnt), 32'd2);

        // ce_pix every third clock: one frame stretched x3
        fs_cnt = 0;
        for (int i = 0; i < 336; i++) begin
            step("ce_div3", (i % 3) == 0, 1'b0, rand_junk(), rand_junk());
            if (frame_start && (i % 3) == 0) fs_cnt++;
        end
        check("div3_frame_start_count", 32'(fs_cnt), 32'd1);

        // Mid-frame reconfiguration of the horizontal timing
        repeat (20) step("pre_cfg", 1'b1, 1'b0, '0, '0);
        step("cfg_offer", 1'b1, 1'b1, pack(10, 12, 14, 16), pv_cfg);
        check("cfg_ready_drop", 32'(cfg_ready), 32'd0);
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            step("cfg_wait", 1'b1, 1'b1, pack(9, 10, 11, 12), pv_cfg);
            done = !m_pend;
        end
        check("cfg_applied", 32'(cfg_ready), 32'd1);
        check("cfg_applied_hcnt", 32'(hcnt), 32'd0);
        for (int i = 0; i < 40; i++) begin
            step("new_line", 1'b1, 1'b0, '0, '0);
            if (hcnt == 12'd10) check("hblank_at_10", 32'(HBlank), 32'd1);
            if (hcnt == 12'd9)  check("hblank_at_9", 32'(HBlank), 32'd0);
        end

        // Illegal offer: ss == se
        step("bad_cfg", 1'b1, 1'b1, pack(8, 12, 12, 14), pv_cfg);
        check("bad_cfg_err", 32'(cfg_err), 32'd1);
        check("bad_cfg_ready", 32'(cfg_ready), 32'd1);
        step("bad_cfg_after", 1'b1, 1'b0, '0, '0);
        check("bad_cfg_err_clear", 32'(cfg_err), 32'd0);

        // Reset while a config is pending at line 3
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            step("seek_v3", 1'b1, 1'b0, '0, '0);
            done = (m_pix / mh.tot) == 3;
        end
        check("reached_v3", 32'(vcnt), 32'd3);
        step("pend_offer", 1'b1, 1'b1, pack(5, 7, 9, 11), pack(2, 3, 4, 6));
        check("pend_ready", 32'(cfg_ready), 32'd0);
        async_reset("rst_pending");
        check("rst_hcnt", 32'(hcnt), 32'd0);
        check("rst_DE", 32'(DE), 32'd1);
        repeat (120) step("post_reset", 1'b1, 1'b0, '0, '0);

        // Randomized enables, offers (legal, junk, and while busy)
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (i == 2000) async_reset("rand_reset");
            if (r < 4)
                step("rand", $urandom_range(0, 3) != 0, 1'b1, rand_legal(9), rand_legal(6));
            else if (r < 8)
                step("rand", $urandom_range(0, 3) != 0, 1'b1, rand_junk(), rand_legal(6));
            else
                step("rand", $urandom_range(0, 3) != 0, 1'b0, rand_junk(), rand_junk());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing generator: the source-side counterpart of the sync/blank cleanup stage. It produces HSync/VSync/HBlank/VBlank/DE with fixed, parameterised sync polarity, together with pixel counters and a frame-start strobe, so that core video logic and the downstream cleaner can be driven from one place. Timing can be changed at run time through a valid/ready handshake, and a new timing only takes effect on a frame boundary.

## Interface
Parameters:
- W, 12: width of every counter and timing field.
- H_ACT / H_SS / H_SE / H_TOT, 320 / 336 / 368 / 426: horizontal active width, sync start, sync end and total, in pixels (reset timing).
- V_ACT / V_SS / V_SE / V_TOT, 240 / 244 / 247 / 262: vertical equivalents, in lines (reset timing).
- HS_POL, 0: HSync active level (0 = active-low).
- VS_POL, 0: VSync active level.

Ports:
- clk_vid  in  1  video clock.
- reset_n  in  1  asynchronous, active-low reset.
- ce_pix  in  1  pixel enable; all timing state advances only on clk_vid edges with ce_pix=1.
- cfg_h  in  4*W  {total, sync_end, sync_start, active}, horizontal.
- cfg_v  in  4*W  same packing, vertical.
- cfg_valid  in  1  new timing offered.
- cfg_ready  out  1  shadow register empty; offer may be accepted.
- cfg_err  out  1  one-clk pulse: offered timing rejected.
- hcnt  out  W  current pixel position.
- vcnt  out  W  current line.
- HSync, VSync, HBlank, VBlank, DE  out  1 each  registered raster signals.
- frame_start  out  1  high for the ce_pix period in which hcnt=0 and vcnt=0.

## Operation
- Live timing registers (act, ss, se, tot, for H and V) load the parameter values on reset.
- On each ce_pix edge:
  - If hcnt = htot-1, hcnt goes to 0; otherwise it increments.
  - On horizontal wrap, vcnt does the same against vtot.
- Decode of the new counter values is registered on the same edge, so outputs always match hcnt/vcnt:
  - HBlank = hcnt >= hact.
  - VBlank = vcnt >= vact.
  - DE = ~(HBlank | VBlank).
  - HSync is at the HS_POL level when hss <= hcnt < hse, and at ~HS_POL otherwise.
  - VSync is at the VS_POL level when vss <= vcnt < vse; it changes only when hcnt becomes 0.
  - frame_start = (hcnt=0 & vcnt=0).
- Config handshake:
  - A transfer occurs on a clk_vid edge with cfg_valid & cfg_ready. This is independent of ce_pix.
  - On transfer, both fields are checked: 0 < act < ss < se <= tot, and tot >= 2.
  - Pass: the fields are copied into the shadow, a pending flag is set, and cfg_ready drops on the next clock.
  - Fail: cfg_err pulses for 1 clk. Nothing is latched and cfg_ready stays 1.
- Apply:
  - On the ce_pix edge where both counters wrap to (0,0), the shadow (if pending) is copied into the live registers, the pending flag clears, and cfg_ready rises on the next clock.
  - The decode on that same edge already uses the new live values.
- Config state machine:
  - IDLE (ready=1) goes to PENDING on an accepted transfer.
  - PENDING (ready=0) goes back to IDLE on frame wrap.
  - A transfer in the same cycle as a wrap is accepted into the shadow and applies at the following wrap.
- Live values are never changed mid-frame. cfg_* inputs are ignored while cfg_ready=0.

## Timing
- Reset values:
  - hcnt=0, vcnt=0, HBlank=0, VBlank=0, DE=1.
  - HSync=~HS_POL, VSync=~VS_POL.
  - frame_start=0, cfg_ready=1, cfg_err=0, pending=0.
- Latency: 0 ce_pix edges between a counter value and its decode. Both are updated on the same edge.
- With ce_pix held low, every output holds. cfg_ready and cfg_err still follow the clock.
- Reset asserted mid-frame or mid-pending:
  - Everything immediately takes the reset values.
  - The shadow is discarded and the live timing reverts to the parameters.
- Counters wrap strictly at tot-1 and never reach tot.

## Test plan
- Small params: H 8/10/12/14 and V 4/5/6/8, ce_pix=1 continuously.
  - Required: a 14-clk line period and a 112-clk frame.
  - HBlank high for hcnt 8..13.
  - HSync low for hcnt 10..11.
  - VSync low for vcnt 5 only.
  - frame_start high once every 112 clks.
- ce_pix asserted every 3rd clk.
  - Required: the same sequence stretched ×3, with all outputs stable between enables.
- Mid-frame, offer cfg_h={16,14,12,10} (total, se, ss, act) with cfg_v unchanged.
  - Required: cfg_ready=0 from the next clk.
  - The current frame completes with the old timing.
  - After the wrap, the line is 16 pixels and HBlank starts at hcnt=10.
  - cfg_ready returns to 1.
- Offer cfg_h with ss=se.
  - Required: cfg_err=1 for 1 clk, cfg_ready stays 1, timing unchanged.
- Assert reset_n=0 while a config is pending at vcnt=3.
  - Required: immediately hcnt=vcnt=0, DE=1, cfg_ready=1.
  - After release, parameter timing resumes.
- HS_POL=1.
  - Required: HSync high only for hcnt 10..11; reset level 0.
